// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial-compare word front end.
//   fe_state_t   : front-end FSM state (IDLE between words, SHIFT while bits go out)
//   RES_*        : {less, eq, greater} result encodings, shared with the bench
//   cnt_width()  : bit-counter width for a given operand width (never below 1)
package serial_cmp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } fe_state_t;

  // Result vector layout is {less, eq, greater}.
  localparam logic [2:0] RES_NONE    = 3'b000;
  localparam logic [2:0] RES_LESS    = 3'b100;
  localparam logic [2:0] RES_EQ      = 3'b010;
  localparam logic [2:0] RES_GREATER = 3'b001;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_msb_shifter.sv
// Parallel-in / serial-out shift register, MSB first, zero fill.
//   clk, rst_n : clock and asynchronous active-low reset (clears the register)
//   load_i     : capture data_i (takes priority over shift_i)
//   shift_i    : shift left by one, inserting 0 at the LSB
//   data_i     : parallel operand
//   msb_o      : current most significant bit
module serial_msb_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = data_i;
    end else if (shift_i) begin
      // Whole-vector shift keeps WIDTH=1 legal (no [WIDTH-2:0] slice).
      sh_d = sh_q << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb_o = sh_q[WIDTH-1];

endmodule

// File: rtl/serial_compare_word_frontend.sv
// Word-level front end for the MSB-first serial comparator.
// Accepts an operand pair over valid/ready, streams it out as bit pairs MSB
// first, keeps the comparator cleared between words and registers the
// comparator's verdict on the LSB cycle as a one-cycle res_valid pulse.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   in_valid/in_ready, in_a/in_b     : operand handshake
//   ser_a/ser_b/ser_valid/ser_last   : bit-pair stream to the comparator
//   ser_clear                        : comparator synchronous clear (high in IDLE)
//   cmp_less/cmp_eq/cmp_greater      : comparator outputs (combinational)
//   res_valid, res_less/eq/greater   : registered result and update pulse
module serial_compare_word_frontend
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             ser_clear,
  input  logic             cmp_less,
  input  logic             cmp_eq,
  input  logic             cmp_greater,
  output logic             res_valid,
  output logic             res_less,
  output logic             res_eq,
  output logic             res_greater
);

  localparam int CW = cnt_width(WIDTH);

  fe_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          res_valid_q;
  logic [2:0]    res_q, res_d;

  logic accept;
  logic shifting;
  logic last_bit;
  logic msb_a, msb_b;

  assign shifting = (state_q == SHIFT);
  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = shifting && (cnt_q == '0);

  serial_msb_shifter #(.WIDTH(WIDTH)) u_shift_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .shift_i (shifting),
    .data_i  (in_a),
    .msb_o   (msb_a)
  );

  serial_msb_shifter #(.WIDTH(WIDTH)) u_shift_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .shift_i (shifting),
    .data_i  (in_b),
    .msb_o   (msb_b)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        if (last_bit) begin
          // Comparator outputs already fold in the LSB presented this cycle.
          state_d = IDLE;
          res_d   = {cmp_less, cmp_eq, cmp_greater};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_q       <= RES_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= last_bit;
      res_q       <= res_d;
    end
  end

  // The IDLE cycle between words doubles as the comparator's clear cycle.
  assign in_ready    = (state_q == IDLE);
  assign ser_clear   = (state_q == IDLE);
  assign ser_valid   = shifting;
  assign ser_last    = last_bit;
  assign ser_a       = shifting & msb_a;
  assign ser_b       = shifting & msb_b;

  assign res_valid   = res_valid_q;
  assign res_less    = res_q[2];
  assign res_eq      = res_q[1];
  assign res_greater = res_q[0];

endmodule
